// File: rtl/contador_modn_cascata_if.sv
// Control/data bundle for the cascadable modulo-N counter.
// The master drives the controls; the counter (slave) drives the status outputs.
interface contador_modn_cascata_if #(
   parameter int DIGITS = 2,
   parameter int DW     = 4
);
   logic                   i_en;
   logic                   i_up;
   logic                   i_loadn;
   logic [DIGITS*DW-1:0]   i_data;
   logic [DIGITS*DW-1:0]   o_count;
   logic                   o_tc;
   logic                   o_zero;
   logic                   o_done;

   modport master (
      output i_en, i_up, i_loadn, i_data,
      input  o_count, o_tc, o_zero, o_done
   );

   modport slave (
      input  i_en, i_up, i_loadn, i_data,
      output o_count, o_tc, o_zero, o_done
   );
endinterface

// File: rtl/contador_modn_cascata.sv
// Cascadable modulo-N up/down counter with synchronous clamped load,
// optional stop-at-terminal mode and a sticky done flag.
module contador_modn_cascata #(
   parameter int DIGITS      = 2,
   parameter int MODULUS     = 10,
   parameter int DW          = 4,
   parameter int STOP_AT_END = 0
) (
   input logic                     clk,
   input logic                     clrn,
   contador_modn_cascata_if.slave  bus
);
   localparam logic [DW-1:0] MAXV = DW'(MODULUS - 1);

   logic [DIGITS*DW-1:0] r_count;
   logic                 r_done;
   logic [DIGITS*DW-1:0] w_count_nxt;
   logic                 w_done_nxt;
   logic [DIGITS:0]      w_carry;
   logic                 w_tc;
   logic                 w_freeze;

   always_comb begin : p_next
      logic [DW-1:0] v_dig;
      logic [DW-1:0] v_fld;
      v_dig       = '0;
      v_fld       = '0;
      w_carry     = '0;
      w_count_nxt = r_count;
      w_done_nxt  = r_done;

      // w_carry[k] = digits 0..k-1 all at terminal, i.e. digit k steps this edge.
      w_carry[0] = 1'b1;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         v_dig        = r_count[k*DW +: DW];
         w_carry[k+1] = w_carry[k] & (bus.i_up ? (v_dig == MAXV) : (v_dig == '0));
      end

      w_tc     = bus.i_en & w_carry[DIGITS];
      w_freeze = (STOP_AT_END != 0) && (r_done || w_tc);

      if (!bus.i_loadn) begin
         for (int unsigned k = 0; k < DIGITS; k++) begin
            v_fld = bus.i_data[k*DW +: DW];
            if (32'(v_fld) >= 32'(MODULUS))
               v_fld = MAXV;
            w_count_nxt[k*DW +: DW] = v_fld;
         end
         w_done_nxt = 1'b0;
      end else if (bus.i_en) begin
         if (w_tc)
            w_done_nxt = 1'b1;
         if (!w_freeze) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
               if (w_carry[k]) begin
                  v_dig = r_count[k*DW +: DW];
                  if (bus.i_up)
                     v_dig = (v_dig == MAXV) ? '0 : v_dig + 1'b1;
                  else
                     v_dig = (v_dig == '0) ? MAXV : v_dig - 1'b1;
                  w_count_nxt[k*DW +: DW] = v_dig;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign bus.o_count = r_count;
   assign bus.o_tc    = w_tc;
   assign bus.o_zero  = (r_count == '0);
   assign bus.o_done  = r_done;
endmodule
